// File: rtl/detection_scheduler.sv
// rtl/detection_scheduler.sv - cascade detection window/stage scheduler (optional watchdog: DET_SCHED_WDOG_EN)
module detection_scheduler #(
  parameter int NUM_STAGES  = 4,
  parameter int NUM_WINDOWS = 4800,
  parameter int WDOG_CYCLES = 4095
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic        iWin_valid,
  input  logic        iFull_FBR,
  input  logic        iFinish_HFG,
  input  logic        iFinish_Stage,
  input  logic        iPass,
  output logic        oReady_HFG,
  output logic        oRun_HFG,
  output logic        oRun_ANN,
  output logic [12:0] oAddr_OM,
  output logic [3:0]  oStage,
  output logic        oWin_done,
  output logic        oFace,
  output logic [12:0] oFace_cnt,
  output logic        oBusy,
  output logic        oFrame_done,
  output logic        oTimeout
);

  typedef enum logic [2:0] {IDLE, WAIT_WIN, HFG, ANN, RETIRE, DONE} state_t;

  localparam logic [3:0]  LAST_STAGE = 4'(NUM_STAGES - 1);
  localparam logic [12:0] LAST_WIN   = 13'(NUM_WINDOWS - 1);
  localparam logic [12:0] CNT_MAX    = 13'h1FFF;

  state_t state;
  logic   wdogHit;

`ifdef DET_SCHED_WDOG_EN
  localparam int WDW = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdogCnt;
  logic           timeoutQ;

  // Watchdog fires once the current HFG/ANN visit has lasted WDOG_CYCLES cycles
  assign wdogHit  = ((state == HFG) || (state == ANN)) && (wdogCnt == WDW'(WDOG_CYCLES - 1));
  assign oTimeout = timeoutQ;
`else
  logic unusedWdog;
  assign unusedWdog = (WDOG_CYCLES != 0);
  assign wdogHit    = 1'b0;
  assign oTimeout   = 1'b0;
`endif

  // Scheduler FSM: every output is a register updated alongside the state
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state       <= IDLE;
      oReady_HFG  <= 1'b0;
      oRun_HFG    <= 1'b0;
      oRun_ANN    <= 1'b0;
      oAddr_OM    <= '0;
      oStage      <= '0;
      oWin_done   <= 1'b0;
      oFace       <= 1'b0;
      oFace_cnt   <= '0;
      oBusy       <= 1'b0;
      oFrame_done <= 1'b0;
`ifdef DET_SCHED_WDOG_EN
      wdogCnt     <= '0;
      timeoutQ    <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; a transition below raises them for one cycle
      oRun_HFG    <= 1'b0;
      oRun_ANN    <= 1'b0;
      oWin_done   <= 1'b0;
      oFace       <= 1'b0;
      oFrame_done <= 1'b0;
`ifdef DET_SCHED_WDOG_EN
      if ((state == HFG) || (state == ANN)) wdogCnt <= wdogCnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (iStart) begin
            oAddr_OM  <= '0;
            oStage    <= '0;
            oFace_cnt <= '0;
            oBusy     <= 1'b1;
`ifdef DET_SCHED_WDOG_EN
            timeoutQ  <= 1'b0;
`endif
            state     <= WAIT_WIN;
          end
        end
        WAIT_WIN: begin
          if (iWin_valid) begin
            oRun_HFG   <= 1'b1;
            oReady_HFG <= 1'b1;
`ifdef DET_SCHED_WDOG_EN
            wdogCnt    <= '0;
`endif
            state      <= HFG;
          end
        end
        HFG: begin
          // Full BRAM and exhausted features are the same event for the classifier
          if (iFull_FBR || iFinish_HFG) begin
            oRun_ANN   <= 1'b1;
            oReady_HFG <= 1'b0;
`ifdef DET_SCHED_WDOG_EN
            wdogCnt    <= '0;
`endif
            state      <= ANN;
          end else if (wdogHit) begin
            oReady_HFG <= 1'b0;
            oWin_done  <= 1'b1;
            oStage     <= '0;
`ifdef DET_SCHED_WDOG_EN
            timeoutQ   <= 1'b1;
`endif
            state      <= RETIRE;
          end
        end
        ANN: begin
          if (iFinish_Stage) begin
            if (iPass && (oStage < LAST_STAGE)) begin
              oStage     <= oStage + 4'd1;
              oRun_HFG   <= 1'b1;
              oReady_HFG <= 1'b1;
`ifdef DET_SCHED_WDOG_EN
              wdogCnt    <= '0;
`endif
              state      <= HFG;
            end else begin
              // Retire bookkeeping is registered here so it is visible during RETIRE
              oWin_done <= 1'b1;
              oStage    <= '0;
              if (iPass) begin
                oFace <= 1'b1;
                if (oFace_cnt != CNT_MAX) oFace_cnt <= oFace_cnt + 13'd1;
              end
              state <= RETIRE;
            end
          end else if (wdogHit) begin
            oWin_done <= 1'b1;
            oStage    <= '0;
`ifdef DET_SCHED_WDOG_EN
            timeoutQ  <= 1'b1;
`endif
            state     <= RETIRE;
          end
        end
        RETIRE: begin
          if (oAddr_OM == LAST_WIN) begin
            oFrame_done <= 1'b1;
            state       <= DONE;
          end else begin
            oAddr_OM <= oAddr_OM + 13'd1;
            state    <= WAIT_WIN;
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
